fb_write_arbiter: RTL and testbench

Shares the single framebuffer BRAM write port (9-bit address, 8-bit data) between two writers: the CPU data bus and the VGA front-panel renderer.
- CPU: memory-mapped window decoded from the 14-bit data address. Writes are buffered in a small FIFO.
- Renderer: valid/ready request port with default priority.
- A starvation guard forces CPU service after a bounded wait.
- Sits between the rj32 data bus, the front-panel block and the framebuffer BRAM, all in one clock domain.

---
 rtl/fb_write_arbiter.sv | 131 +++++++++++++
 tb/tb_fb_write_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: shares the framebuffer BRAM write port between a buffered
// CPU window and the front-panel renderer. The renderer has default priority.
// A starvation guard forces a CPU pop after the FIFO head has waited MAX_WAIT
// cycles.
//
// Renderer handshake: a transfer happens on a rising clock edge when
// pnl_req && pnl_ready. pnl_ready depends only on registered state, not on
// pnl_req. While pnl_req is high and not yet accepted, pnl_addr and pnl_data
// must stay stable. After a transfer the renderer may present a new request in
// the very next cycle.
module fb_write_arbiter #(
  parameter logic [13:0] FB_BASE    = 14'h3E00,
  parameter int          FIFO_DEPTH = 4,
  parameter int          MAX_WAIT   = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [13:0] cpu_addr,
  input  logic [15:0] cpu_data,
  input  logic        cpu_wen,
  output logic        cpu_stall,
  input  logic        pnl_req,
  input  logic [8:0]  pnl_addr,
  input  logic [7:0]  pnl_data,
  output logic        pnl_ready,
  output logic [8:0]  fbw_A,
  output logic [7:0]  fbw_D,
  output logic        fbw_en,
  output logic [2:0]  fifo_level,
  output logic        overflow,
  input  logic        clr_overflow
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LVL_W  = $clog2(FIFO_DEPTH + 1);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  // Each FIFO entry holds {address[8:0], data[7:0]}.
  logic [16:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  level;
  logic [WAIT_W-1:0] wait_cnt;

  logic        hit;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic        force_cpu;
  logic        pnl_win;
  logic [16:0] head;

  // Only the low data byte reaches the framebuffer.
  logic unused_hi;
  assign unused_hi = ^cpu_data[15:8];

  // Address decode, FIFO status and per-cycle arbitration.
  always_comb begin
    hit       = (cpu_addr[13:9] == FB_BASE[13:9]);
    full      = (level == LVL_W'(FIFO_DEPTH));
    empty     = (level == '0);
    force_cpu = (wait_cnt == WAIT_W'(MAX_WAIT));
    // A full FIFO rejects the push even when it pops in the same cycle.
    push      = cpu_wen && hit && !full;
    pnl_win   = pnl_req && !force_cpu;
    // The registered level gates the pop, so a fresh push cannot bypass.
    pop       = !empty && (force_cpu || !pnl_req);
    head      = mem[rd_ptr];
  end

  assign cpu_stall  = full;
  assign pnl_ready  = !force_cpu;
  assign fifo_level = 3'(level);

  // FIFO storage; stale contents are harmless because the level gates reads.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= {cpu_addr[8:0], cpu_data[7:0]};
  end

  // Pointers, occupancy and the starvation wait counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      wait_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
      if (empty || pop)
        wait_cnt <= '0;
      else if (!force_cpu)
        wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  // Sticky overflow; a dropped write wins over a clear in the same cycle.
  always_ff @(posedge clock) begin
    if (reset)
      overflow <= 1'b0;
    else if (cpu_wen && hit && full)
      overflow <= 1'b1;
    else if (clr_overflow)
      overflow <= 1'b0;
  end

  // Output register: the winner's write reaches the BRAM one cycle later.
  always_ff @(posedge clock) begin
    if (reset) begin
      fbw_en <= 1'b0;
      fbw_A  <= '0;
      fbw_D  <= '0;
    end else begin
      fbw_en <= pnl_win || pop;
      if (pnl_win) begin
        fbw_A <= pnl_addr;
        fbw_D <= pnl_data;
      end else if (pop) begin
        fbw_A <= head[16:8];
        fbw_D <= head[7:0];
      end
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter using the default parameters
// (FB_BASE=14'h3E00, FIFO_DEPTH=4, MAX_WAIT=8).
module tb_fb_write_arbiter;

  logic        clock;
  logic        reset;
  logic [13:0] cpu_addr;
  logic [15:0] cpu_data;
  logic        cpu_wen;
  logic        cpu_stall;
  logic        pnl_req;
  logic [8:0]  pnl_addr;
  logic [7:0]  pnl_data;
  logic        pnl_ready;
  logic [8:0]  fbw_A;
  logic [7:0]  fbw_D;
  logic        fbw_en;
  logic [2:0]  fifo_level;
  logic        overflow;
  logic        clr_overflow;

  int total = 0;
  int bad   = 0;

  fb_write_arbiter dut (
    .clock        (clock),
    .reset        (reset),
    .cpu_addr     (cpu_addr),
    .cpu_data     (cpu_data),
    .cpu_wen      (cpu_wen),
    .cpu_stall    (cpu_stall),
    .pnl_req      (pnl_req),
    .pnl_addr     (pnl_addr),
    .pnl_data     (pnl_data),
    .pnl_ready    (pnl_ready),
    .fbw_A        (fbw_A),
    .fbw_D        (fbw_D),
    .fbw_en       (fbw_en),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  // Clock generation
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one edge; observe #1 later, away from the active edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset        = 1'b1;
    cpu_addr     = '0;
    cpu_data     = '0;
    cpu_wen      = 1'b0;
    pnl_req      = 1'b0;
    pnl_addr     = '0;
    pnl_data     = '0;
    clr_overflow = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_level",    16'(fifo_level), 16'd0);
    chk("rst_fbw_en",   16'(fbw_en),     16'd0);
    chk("rst_fbw_A",    16'(fbw_A),      16'd0);
    chk("rst_fbw_D",    16'(fbw_D),      16'd0);
    chk("rst_overflow", 16'(overflow),   16'd0);
    chk("rst_stall",    16'(cpu_stall),  16'd0);
    chk("rst_ready",    16'(pnl_ready),  16'd1);
    reset = 1'b0;
    tick();

    // 1: single CPU window write, renderer idle
    cpu_addr = 14'h3E05; cpu_data = 16'h12AB; cpu_wen = 1'b1;
    tick();
    cpu_wen = 1'b0;
    chk("t1_level1",  16'(fifo_level), 16'd1);
    chk("t1_en_lo",   16'(fbw_en),     16'd0);
    tick();
    chk("t1_level0",  16'(fifo_level), 16'd0);
    chk("t1_en",      16'(fbw_en),     16'd1);
    chk("t1_A",       16'(fbw_A),      16'h005);
    chk("t1_D",       16'(fbw_D),      16'hAB);
    tick();
    chk("t1_idle_en", 16'(fbw_en),     16'd0);
    chk("t1_hold_A",  16'(fbw_A),      16'h005);
    chk("t1_hold_D",  16'(fbw_D),      16'hAB);

    // 2: out-of-window write is ignored
    cpu_addr = 14'h1005; cpu_data = 16'h0055; cpu_wen = 1'b1;
    tick();
    cpu_wen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t2_level",    16'(fifo_level), 16'd0);
      chk("t2_en",       16'(fbw_en),     16'd0);
      chk("t2_overflow", 16'(overflow),   16'd0);
      tick();
    end

    // 3: renderer streams while one CPU entry waits for the starvation guard
    cpu_addr = 14'h3E22; cpu_data = 16'h00C3; cpu_wen = 1'b1;
    pnl_req = 1'b1; pnl_addr = 9'h100; pnl_data = 8'h40;
    chk("t3_ready0", 16'(pnl_ready), 16'd1);
    tick();
    cpu_wen = 1'b0;
    chk("t3_level",  16'(fifo_level), 16'd1);
    chk("t3_en0",    16'(fbw_en),     16'd1);
    chk("t3_A0",     16'(fbw_A),      16'h100);
    for (int i = 1; i <= 8; i++) begin
      pnl_addr = 9'(9'h100 + i);
      pnl_data = 8'(8'h40 + i);
      chk("t3_ready", 16'(pnl_ready), 16'd1);
      tick();
      chk("t3_pnl_en", 16'(fbw_en), 16'd1);
      chk("t3_pnl_A",  16'(fbw_A),  16'(9'h100 + i));
      chk("t3_pnl_D",  16'(fbw_D),  16'(8'h40 + i));
    end
    pnl_addr = 9'h1FF; pnl_data = 8'hEE;
    chk("t3_forced_ready", 16'(pnl_ready), 16'd0);
    tick();
    chk("t3_cpu_en",    16'(fbw_en),     16'd1);
    chk("t3_cpu_A",     16'(fbw_A),      16'h022);
    chk("t3_cpu_D",     16'(fbw_D),      16'hC3);
    chk("t3_drained",   16'(fifo_level), 16'd0);
    chk("t3_resume_rd", 16'(pnl_ready),  16'd1);
    tick();
    chk("t3_resume_A",  16'(fbw_A),      16'h1FF);
    chk("t3_resume_D",  16'(fbw_D),      16'hEE);
    pnl_req = 1'b0;
    tick();

    // 4: five window writes while the renderer holds the port
    pnl_req = 1'b1; pnl_addr = 9'h0AA; pnl_data = 8'h0A;
    for (int k = 0; k < 5; k++) begin
      cpu_addr = 14'(14'h3E40 + k);
      cpu_data = 16'(16'h0060 + k);
      cpu_wen  = 1'b1;
      chk("t4_stall", 16'(cpu_stall), (k == 4) ? 16'd1 : 16'd0);
      tick();
      chk("t4_level", 16'(fifo_level), (k < 4) ? 16'(k + 1) : 16'd4);
      chk("t4_overflow", 16'(overflow), (k == 4) ? 16'd1 : 16'd0);
    end
    cpu_wen = 1'b0;
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    chk("t4_clr", 16'(overflow), 16'd0);

    // 5: drop and clear in the same cycle; the drop wins
    cpu_addr = 14'h3E50; cpu_data = 16'h0077; cpu_wen = 1'b1; clr_overflow = 1'b1;
    chk("t5_stall", 16'(cpu_stall), 16'd1);
    tick();
    cpu_wen = 1'b0; clr_overflow = 1'b0;
    chk("t5_overflow", 16'(overflow),   16'd1);
    chk("t5_level",    16'(fifo_level), 16'd4);
    tick();
    chk("t5_ready_w7", 16'(pnl_ready), 16'd1);
    tick();
    chk("t5_ready_w8", 16'(pnl_ready), 16'd0);
    tick();
    chk("t5_pop_level", 16'(fifo_level), 16'd3);
    chk("t5_pop_en",    16'(fbw_en),     16'd1);
    chk("t5_pop_A",     16'(fbw_A),      16'h040);
    chk("t5_pop_D",     16'(fbw_D),      16'h60);
    chk("t5_ovf_kept",  16'(overflow),   16'd1);

    // 6: reset with three queued entries discards them
    pnl_req = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_level",    16'(fifo_level), 16'd0);
    chk("t6_overflow", 16'(overflow),   16'd0);
    chk("t6_en",       16'(fbw_en),     16'd0);
    chk("t6_stall",    16'(cpu_stall),  16'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t6_no_write", 16'(fbw_en),     16'd0);
      chk("t6_empty",    16'(fifo_level), 16'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
